// File: rtl/activation_unit.sv
// Neuron activation stage: ReLU or sigmoid lookup on a 2*DATA_WIDTH signed sum.
// The variant is chosen at elaboration by ACT_TYPE. Latency is one cycle in every variant.
// The sigmoid ROMs are filled from constant real arithmetic. The output register doubles
// as the synchronous ROM read register.
module activation_unit #(
  parameter int    DATA_WIDTH       = 16,
  parameter int    WEIGHT_INT_WIDTH = 4,
  parameter int    SIGMOID_SIZE     = 10,
  parameter int    X_FRAC           = 5,
  parameter string ACT_TYPE         = "sigmoid_LU"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [2*DATA_WIDTH-1:0]   sum,
  output logic [DATA_WIDTH-1:0]     out,
  output logic                      out_valid
);

  localparam int Msb    = 2 * DATA_WIDTH - 1;
  localparam int XMsb   = Msb - WEIGHT_INT_WIDTH;
  localparam int MaxInt = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic [DATA_WIDTH-1:0] MaxOut = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Half   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  logic                      sign;
  logic                      in_range;
  logic [WEIGHT_INT_WIDTH:0] top_bits;
  logic [DATA_WIDTH-1:0]     act_d;
  logic                      unused_sum;

  assign sign     = sum[Msb];
  assign top_bits = sum[Msb -: WEIGHT_INT_WIDTH + 1];
  // Only a sign-extension of the guard bits fits the truncated field.
  assign in_range = (&top_bits) | ~(|top_bits);
  // Not every variant consumes every bit of the sum.
  assign unused_sum = ^sum;

  if (ACT_TYPE == "relu") begin : g_relu
    // ReLU with saturation when the value exceeds the truncated field.
    always_comb begin
      act_d = '0;
      if (sign) begin
        act_d = '0;
      end else if (!in_range) begin
        act_d = MaxOut;
      end else begin
        act_d = sum[XMsb -: DATA_WIDTH];
      end
    end

  end else if (ACT_TYPE == "sigmoid_nor") begin : g_sig_full
    localparam int RomDepth = 1 << SIGMOID_SIZE;

    logic [DATA_WIDTH-1:0]   rom [RomDepth];
    logic [SIGMOID_SIZE-1:0] x;
    logic [SIGMOID_SIZE-1:0] addr;

    // Entry a holds the rounded sigmoid of (a - RomDepth/2) / 2^X_FRAC.
    for (genvar a = 0; a < RomDepth; a++) begin : g_rom
      localparam real V = $itor(a - RomDepth / 2) / $itor(1 << X_FRAC);
      localparam real Y = $itor(1 << (DATA_WIDTH - 1)) / (1.0 + $exp(-V));
      localparam int  Q = $rtoi(Y + 0.5);
      assign rom[a] = (Q > MaxInt) ? MaxOut : DATA_WIDTH'(Q);
    end

    assign x    = sum[XMsb -: SIGMOID_SIZE];
    // Offset-binary address: flipping the sign bit maps -2^(S-1) to entry 0.
    assign addr = {~x[SIGMOID_SIZE-1], x[SIGMOID_SIZE-2:0]};

    // Full-table lookup with out-of-range clamping.
    always_comb begin
      act_d = '0;
      if (!in_range) begin
        act_d = sign ? '0 : MaxOut;
      end else begin
        act_d = rom[addr];
      end
    end

  end else if (ACT_TYPE == "sigmoid_LU") begin : g_sig_half
    localparam int RomDepth = 1 << (SIGMOID_SIZE - 1);

    logic [DATA_WIDTH-1:0]     rom [RomDepth];
    logic [SIGMOID_SIZE-1:0]   x;
    logic [SIGMOID_SIZE-1:0]   neg_x;
    logic [SIGMOID_SIZE-2:0]   m;

    // Entry m holds the rounded sigmoid of m / 2^X_FRAC (non-negative half only).
    for (genvar a = 0; a < RomDepth; a++) begin : g_rom
      localparam real V = $itor(a) / $itor(1 << X_FRAC);
      localparam real Y = $itor(1 << (DATA_WIDTH - 1)) / (1.0 + $exp(-V));
      localparam int  Q = $rtoi(Y + 0.5);
      assign rom[a] = (Q > MaxInt) ? MaxOut : DATA_WIDTH'(Q);
    end

    assign x     = sum[XMsb -: SIGMOID_SIZE];
    assign neg_x = -x;
    // Only the most-negative x yields a negation with the top bit set; clamp to the last entry.
    assign m     = neg_x[SIGMOID_SIZE-1] ? '1 : neg_x[SIGMOID_SIZE-2:0];

    // Half-table lookup using sigmoid(-v) = 1 - sigmoid(v).
    always_comb begin
      act_d = '0;
      if (!in_range) begin
        act_d = sign ? '0 : MaxOut;
      end else if (!x[SIGMOID_SIZE-1]) begin
        act_d = rom[x[SIGMOID_SIZE-2:0]];
      end else begin
        act_d = Half - rom[m];
      end
    end

  end else begin : g_bad
    $error("activation_unit: unsupported ACT_TYPE %s", ACT_TYPE);
    assign act_d = '0;
  end

  // Output register; recomputed every cycle, qualified by out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= act_d;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: all three variants driven in parallel and
// compared every cycle against a real-arithmetic reference model.
module tb_activation_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sum;
  logic [15:0] out_relu, out_nor, out_lu;
  logic        valid_relu, valid_nor, valid_lu;

  int n_checks = 0;
  int n_pass   = 0;

  activation_unit #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
    .out(out_relu), .out_valid(valid_relu)
  );

  activation_unit #(.ACT_TYPE("sigmoid_nor")) u_nor (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
    .out(out_nor), .out_valid(valid_nor)
  );

  activation_unit #(.ACT_TYPE("sigmoid_LU")) u_lu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
    .out(out_lu), .out_valid(valid_lu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rounded sigmoid in Q1.15, capped at the largest representable code.
  function automatic int t_of(input real v);
    real y;
    int  q;
    y = 32768.0 / (1.0 + $exp(-v));
    q = $rtoi($floor(y + 0.5));
    return (q > 32767) ? 32767 : q;
  endfunction

  function automatic int model_relu(input longint s);
    longint q;
    if (s < 0) return 0;
    q = s / 4096;
    return (q > 32767) ? 32767 : int'(q);
  endfunction

  // Sigmoid of s / 2^23; lu selects the half-table reflection rule for negative arguments.
  function automatic int model_sig(input longint s, input bit lu);
    longint x;
    longint m;
    if (s < -(64'sd1 << 27)) return 0;
    if (s >= (64'sd1 << 27)) return 32767;
    x = s >>> 18;
    if (!lu || x >= 0) return t_of($itor(x) / 32.0);
    m = (-x > 511) ? 511 : -x;
    return 32768 - t_of($itor(m) / 32.0);
  endfunction

  // Apply one input set, then check every output just after the capturing edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] s);
    longint sv;
    int     e_relu, e_nor, e_lu, e_v;
    rst      = r;
    in_valid = v;
    sum      = s;
    @(posedge clk);
    #1;
    sv = longint'($signed(s));
    if (r) begin
      e_relu = 0; e_nor = 0; e_lu = 0; e_v = 0;
    end else begin
      e_relu = model_relu(sv);
      e_nor  = model_sig(sv, 1'b0);
      e_lu   = model_sig(sv, 1'b1);
      e_v    = int'(v);
    end
    check("relu_out",   int'(out_relu),   e_relu);
    check("nor_out",    int'(out_nor),    e_nor);
    check("lu_out",     int'(out_lu),     e_lu);
    check("relu_valid", int'(valid_relu), e_v);
    check("nor_valid",  int'(valid_nor),  e_v);
    check("lu_valid",   int'(valid_lu),   e_v);
  endtask

  initial begin
    int diff;
    rst      = 1'b1;
    in_valid = 1'b0;
    sum      = '0;

    cycle(1'b1, 1'b0, 32'h0000_0000);
    cycle(1'b1, 1'b1, 32'h0080_0000);
    // Load a nonzero result, then reset with in_valid high must clear it.
    cycle(1'b0, 1'b1, 32'h0080_0000);
    cycle(1'b1, 1'b1, 32'h0080_0000);

    // Directed points.
    cycle(1'b0, 1'b1, 32'h0000_0000);
    check("nor_zero", int'(out_nor), 16384);
    check("lu_zero",  int'(out_lu),  16384);
    cycle(1'b0, 1'b1, 32'h0080_0000);
    check("nor_p1",  int'(out_nor),  23955);
    check("relu_p1", int'(out_relu), 2048);
    cycle(1'b0, 1'b0, 32'hFF80_0000);
    check("lu_m1",  int'(out_lu),  8813);
    check("nor_m1", int'(out_nor), 8813);
    cycle(1'b0, 1'b1, 32'h1000_0000);
    check("relu_sat_hi", int'(out_relu), 32767);
    check("lu_sat_hi",   int'(out_lu),   32767);
    cycle(1'b0, 1'b1, 32'hE000_0000);
    check("nor_sat_lo", int'(out_nor), 0);
    cycle(1'b0, 1'b1, 32'h07FF_FFFF);
    cycle(1'b0, 1'b1, 32'hF800_0000);
    cycle(1'b0, 1'b1, 32'h0800_0000);
    cycle(1'b0, 1'b1, 32'hF7FF_FFFF);

    // Back-to-back sweep over every in-range x with random low bits.
    for (int x = -512; x < 512; x++) begin
      int lo;
      lo = int'($urandom_range(0, (1 << 18) - 1));
      cycle(1'b0, 1'b1, 32'(x * 262144 + lo));
      diff = int'(out_lu) - int'(out_nor);
      if (diff < 0) diff = -diff;
      check("lu_vs_nor_tol", int'(diff <= 1), 1);
    end

    // Random traffic: mixed ranges, gaps in in_valid, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] s;
      logic        r;
      logic        v;
      case ($urandom_range(0, 2))
        0:       s = $urandom;
        1:       s = 32'($signed(int'($urandom_range(0, (1 << 28) - 1)) - (1 << 27)));
        default: s = 32'($signed(int'($urandom_range(0, (1 << 29) - 1)) - (1 << 28)));
      endcase
      r = ($urandom_range(0, 49) == 0);
      v = $urandom_range(0, 3) != 0;
      cycle(r, v, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
